secuenciador_dispensado: RTL and testbench

Timed actuator sequencer for the coffee machine. It sits downstream of `maquina_cafe`. Once payment is accepted, it latches the drink configuration (`tamano`, `concentracion`, `nivel_azucar`, `leche`, `espuma`) and drives the grinder, water pump, sugar doser, milk valve and frother through a fixed phase order. Each phase lasts a parameterised number of cycles, and the block reports completion or abort to the machine controller.

---
 rtl/secuenciador_dispensado.sv | 177 +++++++++++++++++
 tb/tb_secuenciador_dispensado.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_dispensado.sv
// Timed actuator sequencer: latches the drink configuration on start and steps
// grinder, pump, sugar doser, milk valve and frother through fixed-length phases.
module secuenciador_dispensado #(
  parameter int unsigned T_MOLIDO = 4,
  parameter int unsigned T_AGUA   = 8,
  parameter int unsigned T_AZUCAR = 2,
  parameter int unsigned T_LECHE  = 6,
  parameter int unsigned T_ESPUMA = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inicio,
  input  logic [1:0] tamano,
  input  logic       concentracion,
  input  logic [3:0] nivel_azucar,
  input  logic       leche,
  input  logic       espuma,
  input  logic       abortar,
  output logic       molino,
  output logic       bomba_agua,
  output logic       dosif_azucar,
  output logic       valvula_leche,
  output logic       espumador,
  output logic       ocupado,
  output logic       listo,
  output logic       abortado
);

  typedef enum logic [2:0] {IDLE, MOLIDO, AGUA, AZUCAR, LECHE, ESPUMA, FIN, ABORT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  tam_q, tam_d;
  logic        conc_q, conc_d;
  logic [3:0]  azu_q, azu_d;
  logic        leche_q, leche_d;
  logic        esp_q, esp_d;
  logic        molino_q, molino_d, bomba_q, bomba_d, azucar_q, azucar_d;
  logic        valvula_q, valvula_d, espuma_q, espuma_d;
  logic        ocupado_q, ocupado_d, listo_q, listo_d, abortado_q, abortado_d;

  logic [1:0]  cfg_tam;
  logic        cfg_conc, cfg_leche, cfg_esp;
  logic [3:0]  cfg_azu;
  logic [7:0]  dur_m, dur_a, dur_z, dur_l, dur_e;
  logic [4:0]  activo;

  // First enabled phase strictly after 'desde'; disabled or zero-length phases fall through.
  function automatic state_t siguiente(input state_t desde, input logic [4:0] act);
    state_t r;
    logic   hallado;
    r = FIN;
    hallado = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (!hallado && act[i] && (i + 1) > 32'(desde)) begin
        r = state_t'(3'(i + 1));
        hallado = 1'b1;
      end
    end
    return r;
  endfunction

  // In IDLE the durations come straight from the inputs so the first phase can load on the start edge.
  always_comb begin
    if (state_q == IDLE) begin
      cfg_tam   = tamano;
      cfg_conc  = concentracion;
      cfg_azu   = nivel_azucar;
      cfg_leche = leche;
      cfg_esp   = espuma;
    end else begin
      cfg_tam   = tam_q;
      cfg_conc  = conc_q;
      cfg_azu   = azu_q;
      cfg_leche = leche_q;
      cfg_esp   = esp_q;
    end
    dur_m  = 8'(T_MOLIDO * (32'(cfg_conc) + 32'd1));
    dur_a  = 8'(T_AGUA * ((cfg_tam == 2'd3) ? 32'd3 : (32'(cfg_tam) + 32'd1)));
    dur_z  = 8'(T_AZUCAR * 32'(cfg_azu));
    dur_l  = cfg_leche ? 8'(T_LECHE) : '0;
    dur_e  = cfg_esp ? 8'(T_ESPUMA) : '0;
    activo = {dur_e != '0, dur_l != '0, dur_z != '0, dur_a != '0, dur_m != '0};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tam_d   = tam_q;
    conc_d  = conc_q;
    azu_d   = azu_q;
    leche_d = leche_q;
    esp_d   = esp_q;
    case (state_q)
      IDLE: begin
        if (inicio) begin
          tam_d   = tamano;
          conc_d  = concentracion;
          azu_d   = nivel_azucar;
          leche_d = leche;
          esp_d   = espuma;
          state_d = siguiente(IDLE, activo);
        end
      end
      MOLIDO, AGUA, AZUCAR, LECHE, ESPUMA: begin
        if (abortar)            state_d = ABORT;
        else if (cnt_q == '0)   state_d = siguiente(state_q, activo);
        else                    cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      case (state_d)
        MOLIDO:  cnt_d = dur_m - 8'd1;
        AGUA:    cnt_d = dur_a - 8'd1;
        AZUCAR:  cnt_d = dur_z - 8'd1;
        LECHE:   cnt_d = dur_l - 8'd1;
        ESPUMA:  cnt_d = dur_e - 8'd1;
        default: cnt_d = '0;
      endcase
    end
    molino_d   = (state_d == MOLIDO);
    bomba_d    = (state_d == AGUA);
    azucar_d   = (state_d == AZUCAR);
    valvula_d  = (state_d == LECHE);
    espuma_d   = (state_d == ESPUMA);
    ocupado_d  = (state_d != IDLE) && (state_d != ABORT);
    listo_d    = (state_d == FIN);
    abortado_d = (state_d == ABORT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tam_q      <= '0;
      conc_q     <= 1'b0;
      azu_q      <= '0;
      leche_q    <= 1'b0;
      esp_q      <= 1'b0;
      molino_q   <= 1'b0;
      bomba_q    <= 1'b0;
      azucar_q   <= 1'b0;
      valvula_q  <= 1'b0;
      espuma_q   <= 1'b0;
      ocupado_q  <= 1'b0;
      listo_q    <= 1'b0;
      abortado_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tam_q      <= tam_d;
      conc_q     <= conc_d;
      azu_q      <= azu_d;
      leche_q    <= leche_d;
      esp_q      <= esp_d;
      molino_q   <= molino_d;
      bomba_q    <= bomba_d;
      azucar_q   <= azucar_d;
      valvula_q  <= valvula_d;
      espuma_q   <= espuma_d;
      ocupado_q  <= ocupado_d;
      listo_q    <= listo_d;
      abortado_q <= abortado_d;
    end
  end

  assign molino        = molino_q;
  assign bomba_agua    = bomba_q;
  assign dosif_azucar  = azucar_q;
  assign valvula_leche = valvula_q;
  assign espumador     = espuma_q;
  assign ocupado       = ocupado_q;
  assign listo         = listo_q;
  assign abortado      = abortado_q;

endmodule

// File: tb/tb_secuenciador_dispensado.sv
// Directed bench for secuenciador_dispensado; outputs packed per cycle as
// {abortado, listo, ocupado, espumador, valvula_leche, dosif_azucar, bomba_agua, molino}.
module tb_secuenciador_dispensado;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       inicio = 1'b0;
  logic [1:0] tamano = '0;
  logic       concentracion = 1'b0;
  logic [3:0] nivel_azucar = '0;
  logic       leche = 1'b0;
  logic       espuma = 1'b0;
  logic       abortar = 1'b0;
  logic       molino, bomba_agua, dosif_azucar, valvula_leche, espumador;
  logic       ocupado, listo, abortado;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] rec [0:63];

  always #5 clock = ~clock;

  secuenciador_dispensado #(
    .T_MOLIDO(4), .T_AGUA(8), .T_AZUCAR(2), .T_LECHE(6), .T_ESPUMA(5)
  ) dut (
    .clock(clock), .reset(reset), .inicio(inicio), .tamano(tamano),
    .concentracion(concentracion), .nivel_azucar(nivel_azucar), .leche(leche),
    .espuma(espuma), .abortar(abortar), .molino(molino), .bomba_agua(bomba_agua),
    .dosif_azucar(dosif_azucar), .valvula_leche(valvula_leche), .espumador(espumador),
    .ocupado(ocupado), .listo(listo), .abortado(abortado)
  );

  function automatic logic [7:0] salidas();
    return {abortado, listo, ocupado, espumador, valvula_leche, dosif_azucar, bomba_agua, molino};
  endfunction

  // Reference timeline: phases abut from cycle 1, listo at 1+sum, idle afterwards.
  function automatic logic [7:0] esperado(input int c, input int lm, input int la,
                                          input int lz, input int ll, input int le);
    int s;
    s = 1;
    if (c >= s && c < s + lm) return 8'h21;
    s += lm;
    if (c >= s && c < s + la) return 8'h22;
    s += la;
    if (c >= s && c < s + lz) return 8'h24;
    s += lz;
    if (c >= s && c < s + ll) return 8'h28;
    s += ll;
    if (c >= s && c < s + le) return 8'h30;
    s += le;
    if (c == s) return 8'h60;
    return 8'h00;
  endfunction

  task automatic set_cfg(input logic [1:0] t, input logic c, input logic [3:0] a,
                         input logic l, input logic e);
    tamano = t; concentracion = c; nivel_azucar = a; leche = l; espuma = e;
  endtask

  // inicio is high into edge 0; rec[c] holds cycle c (after edge c-1); per-cycle events drive edge c.
  task automatic run(input int n, input int abort_c, input int ini_a, input int ini_b,
                     input int rst_c, input bit cambia);
    inicio = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= n; c++) begin
      #1;
      rec[c]  = salidas();
      inicio  = (c == ini_a) || (c == ini_b);
      abortar = (c == abort_c);
      reset   = (c == rst_c);
      if (cambia && c == 1) set_cfg(2'd0, 1'b1, 4'd15, 1'b1, 1'b1);
      @(posedge clock);
    end
    #1;
    inicio = 1'b0; abortar = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; inicio = 1'b1; abortar = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (salidas() !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=%h", salidas(), 8'h00);
    end
    reset = 1'b0; inicio = 1'b0;
    @(posedge clock);
    #1;
    n_checks++;
    if (salidas() !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_in_idle got=%h exp=%h", salidas(), 8'h00);
    end
    abortar = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_minimal();
    set_cfg(2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    run(16, 0, 0, 0, 0, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      n_checks++;
      if (rec[c] !== esperado(c, 4, 8, 0, 0, 0)) begin
        n_fail++;
        $display("FAIL minimal cycle=%0d got=%h exp=%h", c, rec[c], esperado(c, 4, 8, 0, 0, 0));
      end
    end
    n_checks++;
    if (rec[13] !== 8'h60) begin
      n_fail++;
      $display("FAIL minimal_listo13 got=%h exp=%h", rec[13], 8'h60);
    end
  endtask

  task automatic test_full();
    int unos;
    set_cfg(2'd2, 1'b1, 4'd3, 1'b1, 1'b1);
    run(54, 0, 0, 0, 0, 1'b0);
    for (int c = 1; c <= 54; c++) begin
      n_checks++;
      if (rec[c] !== esperado(c, 8, 24, 6, 6, 5)) begin
        n_fail++;
        $display("FAIL full cycle=%0d got=%h exp=%h", c, rec[c], esperado(c, 8, 24, 6, 6, 5));
      end
    end
    unos = 0;
    for (int c = 1; c <= 49; c++) if ($countones(rec[c][4:0]) == 1) unos++;
    n_checks++;
    if (unos !== 49) begin
      n_fail++;
      $display("FAIL full_onehot got=%0d exp=%0d", unos, 49);
    end
  endtask

  task automatic test_saturation();
    set_cfg(2'd3, 1'b0, 4'd0, 1'b0, 1'b0);
    run(32, 0, 0, 0, 0, 1'b1);
    for (int c = 1; c <= 32; c++) begin
      n_checks++;
      if (rec[c] !== esperado(c, 4, 24, 0, 0, 0)) begin
        n_fail++;
        $display("FAIL saturation cycle=%0d got=%h exp=%h", c, rec[c], esperado(c, 4, 24, 0, 0, 0));
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] exp_ab [1:11];
    exp_ab = '{8'h21, 8'h21, 8'h21, 8'h21, 8'h22, 8'h22, 8'h22, 8'h80, 8'h00, 8'h21, 8'h21};
    set_cfg(2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    run(11, 7, 9, 0, 0, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      n_checks++;
      if (rec[c] !== exp_ab[c]) begin
        n_fail++;
        $display("FAIL abort_agua cycle=%0d got=%h exp=%h", c, rec[c], exp_ab[c]);
      end
    end
    // let the restarted drink finish before the next scenario
    repeat (20) @(posedge clock);
    #1;
    run(6, 4, 0, 0, 0, 1'b0);
    n_checks++;
    if (rec[5] !== 8'h80 || rec[6] !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_vs_expiry got=%h,%h exp=%h,%h", rec[5], rec[6], 8'h80, 8'h00);
    end
    run(15, 13, 0, 0, 0, 1'b0);
    for (int c = 12; c <= 15; c++) begin
      n_checks++;
      if (rec[c] !== esperado(c, 4, 8, 0, 0, 0)) begin
        n_fail++;
        $display("FAIL abort_in_fin cycle=%0d got=%h exp=%h", c, rec[c], esperado(c, 4, 8, 0, 0, 0));
      end
    end
  endtask

  task automatic test_back_to_back();
    set_cfg(2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    run(16, 0, 14, 0, 0, 1'b0);
    n_checks++;
    if (rec[13] !== 8'h60 || rec[14] !== 8'h00 || rec[15] !== 8'h21) begin
      n_fail++;
      $display("FAIL back_to_back got=%h,%h,%h exp=60,00,21", rec[13], rec[14], rec[15]);
    end
    repeat (14) @(posedge clock);
    #1;
  endtask

  task automatic test_busy_and_reset();
    set_cfg(2'd2, 1'b1, 4'd3, 1'b1, 1'b1);
    run(56, 0, 3, 20, 0, 1'b0);
    for (int c = 1; c <= 56; c++) begin
      n_checks++;
      if (rec[c] !== esperado(c, 8, 24, 6, 6, 5)) begin
        n_fail++;
        $display("FAIL busy cycle=%0d got=%h exp=%h", c, rec[c], esperado(c, 8, 24, 6, 6, 5));
      end
    end
    // reset during LECHE (cycles 39-44) together with abortar and inicio
    run(56, 40, 40, 0, 40, 1'b0);
    for (int c = 38; c <= 56; c++) begin
      n_checks++;
      if (rec[c] !== ((c <= 40) ? esperado(c, 8, 24, 6, 6, 5) : 8'h00)) begin
        n_fail++;
        $display("FAIL reset_mid cycle=%0d got=%h exp=%h", c, rec[c],
                 (c <= 40) ? esperado(c, 8, 24, 6, 6, 5) : 8'h00);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_minimal();
    test_full();
    test_saturation();
    test_abort();
    test_back_to_back();
    test_busy_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
